// File: rtl/seq_divider_if.sv
// Start/ready request and result bundle between a requester and the shared
// multi-cycle divider.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  quotient, remainder, ready, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output quotient, remainder, ready, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle on magnitudes, with sign
// correction, divide-by-zero and signed-overflow handling in a final FIX cycle.
module seq_divider #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
    logic [WIDTH-1:0] dividend_q, dividend_d, divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d, done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;

    logic [WIDTH:0]   aShift, trial;
    logic             sgnIn, isOvf, negQuot, negRem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        sgnIn   = bus.signed_mode & SIGNED_EN;
        // Partial remainder after the shift can reach 2*M-1, so it needs one extra bit.
        aShift  = {a_q, q_q[WIDTH-1]};
        trial   = aShift - {1'b0, m_q};
        isOvf   = sgn_q && (dividend_q == MOST_NEG) && (divisor_q == '1);
        negQuot = sgn_q & (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
        negRem  = sgn_q & dividend_q[WIDTH-1];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dividend_d = bus.dividend;
                    divisor_d  = bus.divisor;
                    sgn_d      = sgnIn;
                    dbz_d      = 1'b0;
                    ovf_d      = 1'b0;
                    if (bus.divisor == '0) begin
                        state_d = FIX;
                    end else begin
                        a_d     = '0;
                        q_d     = (sgnIn && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
                        m_d     = (sgnIn && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (!trial[WIDTH]) begin
                    a_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    a_d = aShift[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (divisor_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dividend_q;
                    dbz_d       = 1'b1;
                end else if (isOvf) begin
                    quotient_d  = MOST_NEG;
                    remainder_d = '0;
                    ovf_d       = 1'b1;
                end else begin
                    quotient_d  = negQuot ? -q_q : q_q;
                    remainder_d = negRem  ? -a_q : a_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.ready       = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider: three instances (8-bit signed,
// 8-bit with signing disabled, 16-bit) checked against an arithmetic model.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(8))  if8  ();
    seq_divider_if #(.WIDTH(8))  ifU  ();
    seq_divider_if #(.WIDTH(16)) if16 ();

    seq_divider #(.WIDTH(8),  .SIGNED_EN(1'b1)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    seq_divider #(.WIDTH(8),  .SIGNED_EN(1'b0)) dutU  (.clk(clk), .rst(rst), .bus(ifU.slave));
    seq_divider #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

    // Unit 0 = 8-bit signed-capable, 1 = 8-bit unsigned-only, 2 = 16-bit.
    task automatic drive(input int u, input logic st, input logic sm, input logic [31:0] a, input logic [31:0] b);
        case (u)
            0: begin if8.start = st;  if8.signed_mode = sm;  if8.dividend = a[7:0];   if8.divisor = b[7:0];   end
            1: begin ifU.start = st;  ifU.signed_mode = sm;  ifU.dividend = a[7:0];   ifU.divisor = b[7:0];   end
            default: begin if16.start = st; if16.signed_mode = sm; if16.dividend = a[15:0]; if16.divisor = b[15:0]; end
        endcase
    endtask

    task automatic sample(input int u, output logic [31:0] q, output logic [31:0] r, output logic rdy,
                          output logic bsy, output logic dn, output logic dbz, output logic ovf);
        case (u)
            0: begin q = 32'(if8.quotient); r = 32'(if8.remainder); rdy = if8.ready; bsy = if8.busy;
                     dn = if8.done; dbz = if8.div_by_zero; ovf = if8.overflow; end
            1: begin q = 32'(ifU.quotient); r = 32'(ifU.remainder); rdy = ifU.ready; bsy = ifU.busy;
                     dn = ifU.done; dbz = ifU.div_by_zero; ovf = ifU.overflow; end
            default: begin q = 32'(if16.quotient); r = 32'(if16.remainder); rdy = if16.ready; bsy = if16.busy;
                     dn = if16.done; dbz = if16.div_by_zero; ovf = if16.overflow; end
        endcase
    endtask

    // Reference: plain integer division (truncating toward zero) on w-bit values.
    function automatic void model(input int w, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic dbz, output logic ovf);
        longint mask, sa, sb, qq, rr;
        mask = (longint'(1) <<< w) - 1;
        sa   = longint'(a) & mask;
        sb   = longint'(b) & mask;
        dbz  = 1'b0;
        ovf  = 1'b0;
        if (sb == 0) begin
            qq = mask; rr = sa; dbz = 1'b1;
        end else if (sgn) begin
            if (sa >= (longint'(1) <<< (w - 1))) sa = sa - (longint'(1) <<< w);
            if (sb >= (longint'(1) <<< (w - 1))) sb = sb - (longint'(1) <<< w);
            if (sa == -(longint'(1) <<< (w - 1)) && sb == -1) begin
                qq = sa; rr = 0; ovf = 1'b1;
            end else begin
                qq = sa / sb; rr = sa % sb;
            end
        end else begin
            qq = sa / sb; rr = sa % sb;
        end
        q = 32'(qq & mask);
        r = 32'(rr & mask);
    endfunction

    // Counts edges after the accepting edge until done is seen; -1 on timeout.
    task automatic waitDone(input int u, output int cycles);
        logic [31:0] q, r;
        logic rdy, bsy, dn, dbz, ovf;
        cycles = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            sample(u, q, r, rdy, bsy, dn, dbz, ovf);
            if (dn) begin cycles = i; break; end
        end
    endtask

    task automatic checkResult(input int u, input int w, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input int cycles, input string name);
        logic [31:0] q, r, eq, er;
        logic rdy, bsy, dn, dbz, ovf, edbz, eovf;
        int elat;
        model(w, sgn, a, b, eq, er, edbz, eovf);
        elat = edbz ? 1 : w + 1;
        sample(u, q, r, rdy, bsy, dn, dbz, ovf);
        checks++;
        if (cycles !== elat) begin failures++; $display("[TB] FAIL %s latency got=%0d exp=%0d", name, cycles, elat); end
        checks++;
        if (q !== eq) begin failures++; $display("[TB] FAIL %s quotient got=%0h exp=%0h (a=%0h b=%0h)", name, q, eq, a, b); end
        checks++;
        if (r !== er) begin failures++; $display("[TB] FAIL %s remainder got=%0h exp=%0h (a=%0h b=%0h)", name, r, er, a, b); end
        checks++;
        if ({dbz, ovf} !== {edbz, eovf}) begin
            failures++; $display("[TB] FAIL %s flags dbz/ovf got=%b%b exp=%b%b", name, dbz, ovf, edbz, eovf);
        end
        checks++;
        if (rdy !== 1'b1 || bsy !== 1'b0) begin
            failures++; $display("[TB] FAIL %s ready/busy on done got=%b%b exp=10", name, rdy, bsy);
        end
    endtask

    // Full operation; start is held one cycle and operands scrambled right after acceptance.
    task automatic runOp(input int u, input int w, input logic sm, input logic se,
                         input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] q, r;
        logic rdy, bsy, dn, dbz, ovf;
        int cycles;
        drive(u, 1'b1, sm, a, b);
        @(posedge clk); #1;
        drive(u, 1'b0, ~sm, $urandom, $urandom);
        waitDone(u, cycles);
        checkResult(u, w, sm & se, a, b, cycles, name);
        @(posedge clk); #1;
        sample(u, q, r, rdy, bsy, dn, dbz, ovf);
        checks++;
        if (dn !== 1'b0) begin failures++; $display("[TB] FAIL %s done pulse width got=%b exp=0", name, dn); end
    endtask

    task automatic test_reset();
        logic [31:0] q, r;
        logic rdy, bsy, dn, dbz, ovf;
        for (int u = 0; u < 3; u++) begin
            sample(u, q, r, rdy, bsy, dn, dbz, ovf);
            checks++;
            if ({q, r} !== 64'd0 || {rdy, bsy, dn, dbz, ovf} !== 5'b10000) begin
                failures++;
                $display("[TB] FAIL reset unit%0d got q=%0h r=%0h rdy/bsy/dn/dbz/ovf=%b exp 0 0 10000",
                         u, q, r, {rdy, bsy, dn, dbz, ovf});
            end
        end
    endtask

    task automatic test_directed();
        runOp(0, 8, 1'b0, 1'b1, 32'd211, 32'd14, "unsigned_211_14");
        runOp(0, 8, 1'b1, 1'b1, 32'hF9, 32'h02, "signed_m7_2");
        runOp(0, 8, 1'b0, 1'b1, 32'hF9, 32'h02, "unsigned_F9_02");
        runOp(0, 8, 1'b0, 1'b1, 32'd100, 32'd0, "div_by_zero");
        runOp(0, 8, 1'b0, 1'b1, 32'd9, 32'd3, "dbz_cleared");
        runOp(0, 8, 1'b1, 1'b1, 32'h80, 32'hFF, "signed_overflow");
        runOp(0, 8, 1'b1, 1'b1, 32'h81, 32'hFF, "signed_near_overflow");
        runOp(0, 8, 1'b0, 1'b1, 32'hFF, 32'd1, "unsigned_max_by_1");
        runOp(1, 8, 1'b1, 1'b0, 32'h80, 32'hFF, "signed_disabled");
        runOp(1, 8, 1'b1, 1'b0, 32'hF9, 32'h02, "signed_disabled_F9");
        runOp(2, 16, 1'b0, 1'b1, 32'd50000, 32'd7, "w16_50000_7");
        runOp(2, 16, 1'b1, 1'b1, 32'h8000, 32'hFFFF, "w16_overflow");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80; b = 32'hFF; end
            runOp(0, 8, 1'($urandom_range(0, 1)), 1'b1, a, b, "random8");
        end
        for (int i = 0; i < 10; i++) begin
            runOp(1, 8, 1'($urandom_range(0, 1)), 1'b0, $urandom, 32'($urandom_range(1, 255)), "random8u");
            runOp(2, 16, 1'($urandom_range(0, 1)), 1'b1, $urandom, $urandom, "random16");
        end
    endtask

    task automatic test_busy_ignore();
        int cycles;
        drive(0, 1'b1, 1'b0, 32'd200, 32'd7);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 drive(0, 1'b1, 1'b1, 32'h11, 32'h05);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        waitDone(0, cycles);
        checkResult(0, 8, 1'b0, 32'd200, 32'd7, (cycles < 0) ? cycles : cycles + 3, "busy_ignore");
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, r;
        logic rdy, bsy, dn, dbz, ovf;
        logic sawDone;
        drive(0, 1'b1, 1'b0, 32'd250, 32'd3);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        sample(0, q, r, rdy, bsy, dn, dbz, ovf);
        checks++;
        if ({q, r} !== 64'd0 || {rdy, bsy, dn, dbz, ovf} !== 5'b10000) begin
            failures++;
            $display("[TB] FAIL reset_mid got q=%0h r=%0h rdy/bsy/dn/dbz/ovf=%b exp 0 0 10000", q, r, {rdy, bsy, dn, dbz, ovf});
        end
        #2 rst = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            sample(0, q, r, rdy, bsy, dn, dbz, ovf);
            if (dn) sawDone = 1'b1;
        end
        checks++;
        if (sawDone !== 1'b0 || q !== 32'd0) begin
            failures++; $display("[TB] FAIL reset_abort done seen=%b q=%0h exp done=0 q=0", sawDone, q);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q, r;
        logic rdy, bsy, dn, dbz, ovf;
        int cycles;
        drive(0, 1'b1, 1'b0, 32'd100, 32'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        waitDone(0, cycles);
        checkResult(0, 8, 1'b0, 32'd100, 32'd0, cycles, "b2b_first");
        drive(0, 1'b1, 1'b1, 32'hF9, 32'h02);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        sample(0, q, r, rdy, bsy, dn, dbz, ovf);
        checks++;
        if (q !== 32'hFF || r !== 32'd100 || dbz !== 1'b0 || bsy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_accept got q=%0h r=%0h dbz=%b busy=%b exp q=ff r=64 dbz=0 busy=1", q, r, dbz, bsy);
        end
        waitDone(0, cycles);
        checkResult(0, 8, 1'b1, 32'hF9, 32'h02, cycles, "b2b_second");
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 3; u++) drive(u, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised multi-cycle restoring divider. It is the successor to the fixed 8-bit start/ready divider.
- Generalised to WIDTH bits.
- Adds a per-operation signed/unsigned mode, divide-by-zero and signed-overflow flags, and a one-cycle done pulse.
- Sits beside the ALU as a shared long-latency unit behind a start/ready handshake.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
SIGNED_EN, 1, when 0 the signed_mode input is ignored and all divisions are unsigned.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; accepted only on a rising edge where ready=1
signed_mode  in  1  1 = two's-complement operands; sampled with start
dividend  in  WIDTH  numerator; sampled with start
divisor  in  WIDTH  denominator; sampled with start
quotient  out  WIDTH  result; held until the next accepted start
remainder  out  WIDTH  result; held until the next accepted start
ready  out  1  high in IDLE (can accept start)
busy  out  1  high while an operation is in progress (= ~ready)
done  out  1  one-cycle pulse when results become valid
div_by_zero  out  1  status of the last operation; held with the results
overflow  out  1  signed MIN / -1 detected; held with the results

Behaviour:
- Reset (asynchronous): state=IDLE; quotient, remainder, done, div_by_zero and overflow are 0; ready=1, busy=0. Reset mid-operation aborts it; no done pulse.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Latch the operands and the effective mode: sgn = signed_mode & SIGNED_EN.
  - Clear the status flags.
  - If divisor==0: go to FIX with the dbz path.
  - Otherwise: load A=0, Q=|dividend|, M=|divisor| (absolute values only when sgn=1), count=0, go to CALC.
- CALC: one iteration per edge, exactly WIDTH edges.
  - Shift {A,Q} left by 1.
  - T = A - M, computed in WIDTH+1 bits.
  - If T is non-negative: A=T and Q[0]=1; otherwise A is restored (unchanged) and Q[0]=0.
  - count increments each iteration. After the WIDTH-th iteration go to FIX.
  - The counter is clog2(WIDTH)+1 bits and never wraps.
- FIX: one edge; the output registers are loaded and state returns to IDLE.
  - Normal: if sgn and the operand signs differ, quotient=-Q, else quotient=Q. If sgn and the dividend is negative, remainder=-A, else remainder=A. Division truncates toward zero and the remainder takes the dividend's sign.
  - dbz path: quotient = all ones, remainder = the dividend as captured, div_by_zero=1.
  - Overflow (sgn, dividend = most-negative value, divisor = -1): quotient = most-negative value, remainder=0, overflow=1. Latency is unchanged.
- done is a registered pulse asserted for the cycle following the FIX edge, coincident with ready returning to 1.
- Latency from the start edge to the first cycle with done=1:
  - Normal: WIDTH+1 cycles.
  - Divide-by-zero: 1 cycle.
- start while busy is ignored: operands are not re-sampled and there is no effect.
- start on the same edge that done is presented (ready=1) is accepted. A back-to-back operation clears the flags but keeps the old quotient/remainder until its own FIX.
- The operand inputs need only be stable at the accepting edge.

Test Plan:
- WIDTH=8, unsigned, 211/14, start pulsed one cycle → done exactly 9 cycles later; quotient=15, remainder=1, both flags 0.
- WIDTH=8, signed, 0xF9/0x02 (-7/2) → quotient=0xFD (-3), remainder=0xFF (-1). The same operands unsigned → quotient=0x7C, remainder=0x01.
- WIDTH=8, 100/0 → done 1 cycle after start; quotient=0xFF, remainder=100, div_by_zero=1. The next valid division clears the flag.
- WIDTH=8, signed, 0x80/0xFF → quotient=0x80, remainder=0, overflow=1, done at 9 cycles. SIGNED_EN=0 with the same operands → quotient=0, remainder=0x80, overflow=0.
- Reassert start with new operands 3 cycles into an operation → ignored and the original result is delivered. Assert rst at cycle 4 → outputs 0, ready=1, no done pulse. Back-to-back start on the done cycle → second result correct.
- WIDTH=16, unsigned, 50000/7 → quotient=7142, remainder=6, done 17 cycles after start.
